// File: rtl/pc_trace_buffer_if.sv
// rtl/pc_trace_buffer_if.sv - control, status and read-port bundle for pc_trace_buffer
interface pc_trace_buffer_if #(
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 16,
  parameter int STAMP_WIDTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                   arm;
  logic [PC_WIDTH-1:0]    pc;
  logic                   pc_valid;
  logic                   trig_en;
  logic [PC_WIDTH-1:0]    trig_pc;
  logic [AW-1:0]          post_cnt;
  logic [1:0]             state;
  logic                   triggered;
  logic                   done;
  logic [AW:0]            count;
  logic [AW-1:0]          rd_idx;
  logic [PC_WIDTH-1:0]    rd_pc;
  logic [STAMP_WIDTH-1:0] rd_stamp;

  modport master (
    output arm, pc, pc_valid, trig_en, trig_pc, post_cnt, rd_idx,
    input  state, triggered, done, count, rd_pc, rd_stamp
  );

  modport slave (
    input  arm, pc, pc_valid, trig_en, trig_pc, post_cnt, rd_idx,
    output state, triggered, done, count, rd_pc, rd_stamp
  );
endinterface

// File: rtl/pc_trace_buffer.sv
// rtl/pc_trace_buffer.sv - PC history ring buffer with trigger and post-trigger window
// Entries are {pc, stamp}; reads are combinational and indexed oldest-first.
module pc_trace_buffer #(
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 16,
  parameter int STAMP_WIDTH = 16,
  parameter bit DEDUP       = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  pc_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_POST    = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AW-1:0]          r_wptr;
  logic [AW:0]            r_count;
  logic [STAMP_WIDTH-1:0] r_stamp;
  logic                   r_triggered;
  logic [PC_WIDTH-1:0]    r_last_pc;
  logic                   r_last_vld;
  logic [AW-1:0]          r_remaining;

  logic [PC_WIDTH-1:0]    r_ring_pc    [DEPTH];
  logic [STAMP_WIDTH-1:0] r_ring_stamp [DEPTH];

  logic                   w_active;
  logic                   w_new_pc;
  logic                   w_write;
  logic                   w_trig_hit;
  logic [AW-1:0]          w_rd_phys;
  logic                   w_rd_ok;

  always_comb begin
    w_active    = (r_state == S_CAPTURE) || (r_state == S_POST);
    w_new_pc    = !DEDUP || !r_last_vld || (bus.pc != r_last_pc);
    w_write     = !bus.arm && w_active && bus.pc_valid && w_new_pc;
    w_trig_hit  = w_write && (r_state == S_CAPTURE) && bus.trig_en &&
                  (bus.pc == bus.trig_pc);
    w_state_nxt = r_state;
    if (bus.arm) begin
      w_state_nxt = S_CAPTURE;
    end else begin
      case (r_state)
        S_CAPTURE: if (w_trig_hit)
                     w_state_nxt = (r_remaining == '0) ? S_DONE : S_POST;
        // remaining counts post-trigger writes still owed; the last one closes the window
        S_POST:    if (w_write && (r_remaining == AW'(1)))
                     w_state_nxt = S_DONE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_count     <= '0;
      r_stamp     <= '0;
      r_triggered <= 1'b0;
      r_last_pc   <= '0;
      r_last_vld  <= 1'b0;
      r_remaining <= '0;
    end else if (bus.arm) begin
      r_wptr      <= '0;
      r_count     <= '0;
      r_stamp     <= '0;
      r_triggered <= 1'b0;
      r_last_vld  <= 1'b0;
      r_remaining <= bus.post_cnt;
    end else begin
      if (w_active) r_stamp <= r_stamp + STAMP_WIDTH'(1);
      if (w_write) begin
        r_wptr     <= r_wptr + AW'(1);
        r_last_pc  <= bus.pc;
        r_last_vld <= 1'b1;
        if (r_count != FULL)     r_count     <= r_count + (AW+1)'(1);
        if (r_state == S_POST)   r_remaining <= r_remaining - AW'(1);
      end
      if (w_trig_hit) r_triggered <= 1'b1;
    end
  end

  // Ring storage carries no reset: entries beyond count are never exposed.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_ring_pc[r_wptr]    <= bus.pc;
      r_ring_stamp[r_wptr] <= r_stamp;
    end
  end

  // At saturation count[AW-1:0] is zero, so the oldest entry sits at wptr.
  assign w_rd_phys = r_wptr - r_count[AW-1:0] + bus.rd_idx;
  assign w_rd_ok   = {1'b0, bus.rd_idx} < r_count;

  assign bus.state     = r_state;
  assign bus.triggered = r_triggered;
  assign bus.done      = (r_state == S_DONE);
  assign bus.count     = r_count;
  assign bus.rd_pc     = w_rd_ok ? r_ring_pc[w_rd_phys]    : '0;
  assign bus.rd_stamp  = w_rd_ok ? r_ring_stamp[w_rd_phys] : '0;
endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb/tb_pc_trace_buffer.sv - bench for pc_trace_buffer, DEDUP=1 and DEDUP=0 side by side
// Expected contents come from a queue-based history model of the capture rules.
`timescale 1ns/1ps
module tb_pc_trace_buffer;
  localparam int PW = 32;
  localparam int D  = 16;
  localparam int SW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          drv_arm = 1'b0;
  logic [PW-1:0] drv_pc  = '0;
  logic          drv_pv  = 1'b0;
  logic          drv_te  = 1'b0;
  logic [PW-1:0] drv_tp  = '0;
  logic [AW-1:0] drv_pcnt = '0;
  logic [AW-1:0] drv_rd  = '0;

  pc_trace_buffer_if #(.PC_WIDTH(PW), .DEPTH(D), .STAMP_WIDTH(SW)) bus_d ();
  pc_trace_buffer_if #(.PC_WIDTH(PW), .DEPTH(D), .STAMP_WIDTH(SW)) bus_n ();

  assign bus_d.arm = drv_arm;   assign bus_n.arm = drv_arm;
  assign bus_d.pc = drv_pc;     assign bus_n.pc = drv_pc;
  assign bus_d.pc_valid = drv_pv; assign bus_n.pc_valid = drv_pv;
  assign bus_d.trig_en = drv_te; assign bus_n.trig_en = drv_te;
  assign bus_d.trig_pc = drv_tp; assign bus_n.trig_pc = drv_tp;
  assign bus_d.post_cnt = drv_pcnt; assign bus_n.post_cnt = drv_pcnt;
  assign bus_d.rd_idx = drv_rd; assign bus_n.rd_idx = drv_rd;

  pc_trace_buffer #(.PC_WIDTH(PW), .DEPTH(D), .STAMP_WIDTH(SW), .DEDUP(1'b1)) u_dut_d (
    .clk(clk), .rst(rst), .bus(bus_d));
  pc_trace_buffer #(.PC_WIDTH(PW), .DEPTH(D), .STAMP_WIDTH(SW), .DEDUP(1'b0)) u_dut_n (
    .clk(clk), .rst(rst), .bus(bus_n));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: index 0 = DEDUP=1 instance, index 1 = DEDUP=0 instance
  typedef struct packed {
    logic [PW-1:0] pc;
    logic [SW-1:0] stamp;
  } ent_t;

  ent_t          mq_d[$];
  ent_t          mq_n[$];
  int            m_state[2];
  logic [SW-1:0] m_stamp[2];
  bit            m_trig[2];
  int            m_rem[2];
  logic [PW-1:0] m_last[2];
  bit            m_lastv[2];

  function automatic int m_size(input int k);
    return (k == 0) ? mq_d.size() : mq_n.size();
  endfunction

  function automatic ent_t m_get(input int k, input int i);
    return (k == 0) ? mq_d[i] : mq_n[i];
  endfunction

  task automatic m_push(input int k, input ent_t e);
    if (k == 0) begin
      mq_d.push_back(e);
      if (mq_d.size() > D) void'(mq_d.pop_front());
    end else begin
      mq_n.push_back(e);
      if (mq_n.size() > D) void'(mq_n.pop_front());
    end
  endtask

  task automatic m_clear(input int k);
    if (k == 0) mq_d.delete();
    else        mq_n.delete();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_clear(k);
      m_state[k] = 0; m_stamp[k] = '0; m_trig[k] = 0;
      m_rem[k] = 0; m_last[k] = '0; m_lastv[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit   wr;
    ent_t e;
    int   st;
    st = m_state[k];
    if (drv_arm) begin
      m_clear(k);
      m_stamp[k] = '0; m_trig[k] = 0; m_lastv[k] = 0;
      m_rem[k] = int'(drv_pcnt); m_state[k] = 1;
      return;
    end
    if (st == 1 || st == 2) begin
      wr = drv_pv && (k == 1 || !m_lastv[k] || drv_pc != m_last[k]);
      if (wr) begin
        e.pc = drv_pc; e.stamp = m_stamp[k];
        m_push(k, e);
        m_last[k] = drv_pc; m_lastv[k] = 1;
        if (st == 1 && drv_te && drv_pc == drv_tp) begin
          m_trig[k] = 1;
          m_state[k] = (m_rem[k] == 0) ? 3 : 2;
        end else if (st == 2) begin
          m_rem[k]--;
          if (m_rem[k] == 0) m_state[k] = 3;
        end
      end
      m_stamp[k] = m_stamp[k] + 1'b1;
    end
  endtask

  task automatic check_all();
    ent_t e;
    check("d.state", bus_d.state, m_state[0]);
    check("n.state", bus_n.state, m_state[1]);
    check("d.count", bus_d.count, m_size(0));
    check("n.count", bus_n.count, m_size(1));
    check("d.triggered", bus_d.triggered, m_trig[0]);
    check("n.triggered", bus_n.triggered, m_trig[1]);
    check("d.done", bus_d.done, m_state[0] == 3);
    check("n.done", bus_n.done, m_state[1] == 3);
    for (int i = 0; i < D; i++) begin
      drv_rd = i[AW-1:0];
      #0.1;
      e = (i < m_size(0)) ? m_get(0, i) : '0;
      check($sformatf("d.rd_pc[%0d]", i), bus_d.rd_pc, e.pc);
      check($sformatf("d.rd_stamp[%0d]", i), bus_d.rd_stamp, e.stamp);
      e = (i < m_size(1)) ? m_get(1, i) : '0;
      check($sformatf("n.rd_pc[%0d]", i), bus_n.rd_pc, e.pc);
      check($sformatf("n.rd_stamp[%0d]", i), bus_n.rd_stamp, e.stamp);
    end
  endtask

  task automatic cycle(input bit a, input logic [PW-1:0] p, input bit pv);
    drv_arm = a; drv_pc = p; drv_pv = pv;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset pulse placed between clock edges to exercise the asynchronous path.
  task automatic pulse_rst();
    #1;
    rst = 1'b1;
    #0.5;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // continuous capture, five distinct PCs
    drv_te = 1'b0;
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 32'(i * 4), 1);
    check("basic.count", bus_d.count, 5);

    // overflow: 20 PCs into 16 entries
    cycle(1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 32'(i * 4), 1);
    drv_rd = 4'd0; #0.1;
    check("wrap.oldest", bus_d.rd_pc, 16);
    drv_rd = 4'd15; #0.1;
    check("wrap.newest", bus_d.rd_pc, 76);

    // stall suppression: 8,8,8,12
    cycle(1, 0, 0);
    cycle(0, 8, 1); cycle(0, 8, 1); cycle(0, 8, 1); cycle(0, 12, 1);
    check("dedup.count_d", bus_d.count, 2);
    check("dedup.count_n", bus_n.count, 4);

    // trigger at 0x20 with three post-trigger entries
    drv_te = 1'b1; drv_tp = 32'h20; drv_pcnt = 4'd3;
    cycle(1, 0, 0);
    for (int p = 'h10; p <= 'h40; p += 4) cycle(0, 32'(p), 1);
    check("trig.count", bus_d.count, 8);

    // arm during DONE restarts with stamp 0
    drv_tp = 32'h100; drv_pcnt = 4'd0;
    cycle(1, 0, 0);
    cycle(0, 32'h100, 1);
    cycle(0, 32'h104, 1);
    cycle(0, 32'h108, 1);

    // post window with pc_valid gaps, then reset mid-POST
    drv_tp = 32'h200; drv_pcnt = 4'd3;
    cycle(1, 0, 0);
    cycle(0, 32'h1fc, 1);
    cycle(0, 32'h200, 1);
    cycle(0, 32'h204, 0); cycle(0, 32'h204, 0); cycle(0, 32'h204, 1);
    cycle(0, 32'h208, 0);
    pulse_rst();
    cycle(0, 32'h20c, 1);

    // arm coinciding with a trigger match
    drv_tp = 32'h300; drv_pcnt = 4'd0;
    cycle(1, 0, 0);
    cycle(0, 32'h2fc, 1);
    cycle(1, 32'h300, 1);
    cycle(0, 32'h304, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) drv_te = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) drv_tp = 32'($urandom_range(0, 15) * 4);
      drv_pcnt = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) pulse_rst();
      cycle($urandom_range(0, 39) == 0, 32'($urandom_range(0, 15) * 4),
            $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
